// File: rtl/de2_req_ack_rx_pkg.sv
// Shared definitions for the DE2 four-phase request/acknowledge receiver:
// FSM states, Avalon register map and register bit positions.
package de2_req_ack_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    TOUT
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CMD    = 2'd3;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_TOUT_BIT  = 2;
  localparam int STAT_COUNT_LSB = 4;

  localparam int CTRL_IRQ_EN_BIT   = 0;
  localparam int CTRL_IRQ_TOUT_BIT = 1;

  localparam int CMD_CLR_TOUT_BIT = 0;
  localparam int CMD_FLUSH_BIT    = 1;

endpackage

// File: rtl/de2_rx_fifo.sv
// Receive FIFO: pop on empty is ignored and reads 0, flush beats push/pop,
// pointers wrap naturally because DEPTH is a power of two.
module de2_rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // sampled only at the rising edge like any other input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; empty/count gate every
  // read, so stale contents are never visible and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/de2_req_ack_rx.sv
// Four-phase req/ack receiver that queues board-side data words into a FIFO
// and exposes them, with status, control and interrupt, on an Avalon-MM slave.
module de2_req_ack_rx
  import de2_req_ack_rx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic              ext_req,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ack
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              req_m;
  logic              req_s;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tout;
  logic              irq_en;
  logic              irq_on_tout;

  logic              rd_strobe;
  logic              wr_strobe;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              clr_tout;
  logic              writedata_unused;

  assign rd_strobe  = chipselect & ~read_n;
  assign wr_strobe  = chipselect & ~write_n;
  assign fifo_pop   = rd_strobe & (address == ADDR_DATA);
  assign fifo_flush = wr_strobe & (address == ADDR_CMD) & writedata[CMD_FLUSH_BIT];
  assign clr_tout   = wr_strobe & (address == ADDR_CMD) & writedata[CMD_CLR_TOUT_BIT];
  // ext_data is captured straight into the FIFO on the IDLE->ACK cycle.
  assign fifo_push  = (state == IDLE) & req_s & ~fifo_full;
  assign irq        = (irq_en & ~fifo_empty) | (irq_on_tout & tout);
  assign writedata_unused = ^writedata[31:2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= ext_req;
      req_s <= req_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      ext_ack  <= 1'b0;
      wait_cnt <= '0;
      tout     <= 1'b0;
    end else begin
      if (clr_tout) tout <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s && !fifo_full) begin
            state    <= ACK;
            ext_ack  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ACK: begin
          if (wait_cnt != WAIT_W'(TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
          if (!req_s) begin
            state   <= IDLE;
            ext_ack <= 1'b0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // A new timeout beats a simultaneous clear so the event is not lost.
            state   <= TOUT;
            ext_ack <= 1'b0;
            tout    <= 1'b1;
          end
        end
        TOUT: begin
          if (!req_s) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ext_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en      <= 1'b0;
      irq_on_tout <= 1'b0;
    end else if (wr_strobe && address == ADDR_CTRL) begin
      irq_en      <= writedata[CTRL_IRQ_EN_BIT];
      irq_on_tout <= writedata[CTRL_IRQ_TOUT_BIT];
    end
  end

  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(fifo_dout);
      ADDR_STATUS: begin
        readdata[STAT_EMPTY_BIT]         = fifo_empty;
        readdata[STAT_FULL_BIT]          = fifo_full;
        readdata[STAT_TOUT_BIT]          = tout;
        readdata[STAT_COUNT_LSB +: 4]    = 4'(fifo_count);
      end
      ADDR_CTRL: begin
        readdata[CTRL_IRQ_EN_BIT]   = irq_en;
        readdata[CTRL_IRQ_TOUT_BIT] = irq_on_tout;
      end
      default: readdata = '0;
    endcase
  end

  de2_rx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .din    (ext_data),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_de2_req_ack_rx.sv
// Directed bench for de2_req_ack_rx: register reads go through a scoreboard
// queue drained by a negedge monitor; handshake/irq levels are checked inline.
module tb_de2_req_ack_rx;
  import de2_req_ack_rx_pkg::*;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        ext_req;
  logic [15:0] ext_data;
  logic        ext_ack;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  de2_req_ack_rx #(
    .DATA_W (16),
    .DEPTH  (4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read_n    (read_n),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .ext_req   (ext_req),
    .ext_data  (ext_data),
    .ext_ack   (ext_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every read strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    if (chipselect && !read_n) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", readdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, readdata, e.value);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] status(input int cnt, input bit to, input bit fl, input bit em);
    logic [31:0] r;
    r      = '0;
    r[7:4] = 4'(cnt);
    r[2]   = to;
    r[1]   = fl;
    r[0]   = em;
    return r;
  endfunction

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name  = name;
    e.value = exp;
    sb.push_back(e);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_ack(input logic level, input string name);
    int n;
    n = 0;
    while (ext_ack !== level && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(ext_ack), 32'(level));
  endtask

  task automatic send(input logic [15:0] d, input string name);
    ext_data = d;
    ext_req  = 1'b1;
    wait_ack(1'b1, {name, "_ack_hi"});
    ext_req = 1'b0;
    wait_ack(1'b0, {name, "_ack_lo"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    ext_req    = 1'b0;
    ext_data   = '0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_ack", 32'(ext_ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    bus_read(ADDR_STATUS, status(0, 0, 0, 1), "rst_status");
    bus_read(ADDR_DATA, 32'h0, "rst_empty_data");
    bus_read(ADDR_CTRL, 32'h0, "rst_ctrl");
    bus_read(ADDR_CMD, 32'h0, "unmapped_read");

    // Single transfer and ack latency
    ext_data = 16'h1234;
    ext_req  = 1'b1;
    tick();
    tick();
    check("ack_not_early", 32'(ext_ack), 32'd0);
    tick();
    check("ack_latency3", 32'(ext_ack), 32'd1);
    ext_req = 1'b0;
    wait_ack(1'b0, "single_ack_lo");
    bus_read(ADDR_STATUS, status(1, 0, 0, 0), "single_status");
    bus_read(ADDR_DATA, 32'h0000_1234, "single_data");
    bus_read(ADDR_STATUS, status(0, 0, 0, 1), "single_empty");

    // Backpressure: fifth transfer withheld until a pop
    for (int i = 0; i < 4; i++) send(16'hA0 + 16'(i), "fill");
    bus_read(ADDR_STATUS, status(4, 0, 1, 0), "full_status");
    ext_data = 16'h00A4;
    ext_req  = 1'b1;
    repeat (10) tick();
    check("full_ack_withheld", 32'(ext_ack), 32'd0);
    bus_read(ADDR_DATA, 32'h0000_00A0, "full_pop_a0");
    wait_ack(1'b1, "fifth_ack_hi");
    ext_req = 1'b0;
    wait_ack(1'b0, "fifth_ack_lo");
    bus_read(ADDR_STATUS, status(4, 0, 1, 0), "refull_status");
    for (int i = 1; i < 5; i++) bus_read(ADDR_DATA, 32'h0000_00A0 + 32'(i), "drain_order");
    bus_read(ADDR_STATUS, status(0, 0, 0, 1), "drain_empty");

    // Push and pop in the same cycle with count=2
    send(16'hB000, "pp_b0");
    send(16'hB001, "pp_b1");
    ext_data = 16'hB002;
    ext_req  = 1'b1;
    tick();
    tick();
    bus_read(ADDR_DATA, 32'h0000_B000, "pp_pop_b0");
    check("pp_ack_hi", 32'(ext_ack), 32'd1);
    bus_read(ADDR_STATUS, status(2, 0, 0, 0), "pp_count2");
    ext_req = 1'b0;
    wait_ack(1'b0, "pp_ack_lo");
    bus_read(ADDR_DATA, 32'h0000_B001, "pp_b1");
    bus_read(ADDR_DATA, 32'h0000_B002, "pp_b2");

    // Push and pop in the same cycle while empty
    ext_data = 16'h0D0D;
    ext_req  = 1'b1;
    tick();
    tick();
    bus_read(ADDR_DATA, 32'h0, "ppe_pop_zero");
    bus_read(ADDR_STATUS, status(1, 0, 0, 0), "ppe_push_landed");
    ext_req = 1'b0;
    wait_ack(1'b0, "ppe_ack_lo");
    bus_read(ADDR_DATA, 32'h0000_0D0D, "ppe_data");

    // Interrupt on non-empty and flush
    bus_write(ADDR_CTRL, 32'h1);
    bus_read(ADDR_CTRL, 32'h1, "ctrl_readback");
    check("irq_empty", 32'(irq), 32'd0);
    send(16'h1111, "irq_push");
    check("irq_nonempty", 32'(irq), 32'd1);
    bus_read(ADDR_DATA, 32'h0000_1111, "irq_pop_data");
    check("irq_after_pop", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) send(16'h2220 + 16'(i), "flush_fill");
    bus_read(ADDR_STATUS, status(3, 0, 0, 0), "flush_count3");
    bus_write(ADDR_CMD, 32'h2);
    bus_read(ADDR_STATUS, status(0, 0, 0, 1), "flush_empty");
    check("irq_after_flush", 32'(irq), 32'd0);

    // Flush in the same cycle as a push
    ext_data = 16'h0F0F;
    ext_req  = 1'b1;
    tick();
    tick();
    bus_write(ADDR_CMD, 32'h2);
    bus_read(ADDR_STATUS, status(0, 0, 0, 1), "flush_beats_push");
    ext_req = 1'b0;
    wait_ack(1'b0, "fp_ack_lo");

    // Timeout
    bus_write(ADDR_CTRL, 32'h2);
    ext_data = 16'h7777;
    ext_req  = 1'b1;
    wait_ack(1'b1, "tout_ack_hi");
    n = 0;
    while (ext_ack === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("tout_ack_cycles", 32'(n), 32'(TIMEOUT));
    check("tout_irq", 32'(irq), 32'd1);
    bus_read(ADDR_STATUS, status(1, 1, 0, 0), "tout_status");
    ext_req = 1'b0;
    repeat (4) tick();
    check("tout_ack_stays_lo", 32'(ext_ack), 32'd0);
    bus_write(ADDR_CMD, 32'h1);
    bus_read(ADDR_STATUS, status(1, 0, 0, 0), "tout_cleared");
    check("tout_irq_cleared", 32'(irq), 32'd0);
    bus_read(ADDR_DATA, 32'h0000_7777, "tout_data");

    // Reset during ACK with req held high
    ext_data = 16'h5A5A;
    ext_req  = 1'b1;
    wait_ack(1'b1, "rstack_ack_hi");
    reset_n = 1'b0;
    tick();
    check("rstack_ack_dropped", 32'(ext_ack), 32'd0);
    reset_n = 1'b1;
    bus_read(ADDR_STATUS, status(0, 0, 0, 1), "rstack_fifo_empty");
    tick();
    check("rstack_sync_delay", 32'(ext_ack), 32'd0);
    tick();
    check("rstack_recapture", 32'(ext_ack), 32'd1);
    ext_req = 1'b0;
    wait_ack(1'b0, "rstack_ack_lo");
    bus_read(ADDR_CTRL, 32'h0, "rstack_ctrl_cleared");
    check("rstack_irq", 32'(irq), 32'd0);
    bus_read(ADDR_STATUS, status(1, 0, 0, 0), "rstack_one_entry");
    bus_read(ADDR_DATA, 32'h0000_5A5A, "rstack_data");

    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/de2_req_ack_rx.md
DE2_REQ_ACK_RX -- requirements
Module: de2_req_ack_rx

Interface
REQ-001 Parameter DATA_W, default 16, width of the external data bus and of each FIFO entry.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, minimum 2.
REQ-003 Parameter TIMEOUT, default 1023, maximum number of cycles ACK waits for req to fall.
REQ-004 Port clk, input, 1, the single clock; every register is clocked on the rising edge.
REQ-005 Port reset_n, input, 1, synchronous active-low reset.
REQ-006 Port address, input, 2, Avalon-MM slave register select.
REQ-007 Port chipselect, input, 1, Avalon-MM slave select.
REQ-008 Port read_n, input, 1, active-low read strobe.
REQ-009 Port write_n, input, 1, active-low write strobe.
REQ-010 Port writedata, input, 32, write data.
REQ-011 Port readdata, output, 32, combinational read data; zero-extended.
REQ-012 Port irq, output, 1, level interrupt.
REQ-013 Port ext_req, input, 1, asynchronous request from the board-side source.
REQ-014 Port ext_data, input, DATA_W, source data; stable while ext_req is high.
REQ-015 Port ext_ack, output, 1, registered four-phase acknowledge to the source.

Function
REQ-016 ext_req is synchronized through 2 flops (req_s); ext_data is sampled only on the cycle the FSM leaves IDLE.
REQ-017 FSM IDLE: ext_ack=0; moves to ACK when req_s=1 and the FIFO is not full, pushing ext_data in the same cycle.
REQ-018 FSM ACK: ext_ack=1; returns to IDLE when req_s=0; moves to TOUT when the wait counter reaches TIMEOUT.
REQ-019 FSM TOUT: ext_ack=0; sets sticky flag tout; returns to IDLE when req_s=0.
REQ-020 When the FIFO is full and req_s=1, the FSM stays in IDLE with ack low (backpressure); no data is lost or overwritten.
REQ-021 Wait counter clears on entry to ACK and saturates at TIMEOUT.
REQ-022 Address 0 read returns the FIFO head, zero-extended; a read strobe (chipselect & ~read_n) pops one entry.
REQ-023 Address 0 read when empty returns 0 and changes no state.
REQ-024 Address 1 read returns status: bit0 empty, bit1 full, bit2 tout, bits[7:4] count.
REQ-025 Address 2 read/write is control: bit0 irq_en; bit1 irq_on_tout.
REQ-026 A write to address 3 with writedata bit0=1 clears tout; bit1=1 flushes the FIFO.
REQ-027 irq = (irq_en & ~empty) | (irq_on_tout & tout).
REQ-028 A simultaneous push and pop leaves count unchanged; when the FIFO is empty, the popped data is 0 and the push still lands.
REQ-029 Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-030 A flush in the same cycle as a push leaves the FIFO empty; flush has priority.
REQ-031 Unused readdata bits and unmapped addresses read 0.

Reset
REQ-032 With reset_n=0 at a clock edge: FSM=IDLE, ext_ack=0, FIFO empty, count=0, tout=0, irq_en=0, irq_on_tout=0, synchronizer flops=0, and wait counter=0.
REQ-033 Reset during ACK drops ext_ack on the next edge; a source holding req high after reset is re-captured as a new transfer.

Structure
REQ-034 A shared package holds the FSM state enum (IDLE, ACK, TOUT), the register address constants (0..3) and the status bit positions.
REQ-035 The FIFO is one sub-module, de2_rx_fifo (parameters DATA_W and DEPTH; ports push, pop, flush, din, dout, count, full and empty).

Verification
REQ-036 Scenario: ext_data=0x1234 with req pulsed -> ack rises 3 cycles after req; one entry; address 0 read returns 0x00001234; then empty.
REQ-037 Scenario: 5 transfers with DEPTH=4 and no reads -> 5th ack withheld; status full=1, count=4; one pop -> 5th transfer completes.
REQ-038 Scenario: req held high with TIMEOUT=1023 -> ack falls at cycle 1023 in ACK; tout=1; irq asserts if irq_on_tout; write 0x1 to address 3 clears tout.
REQ-039 Scenario: push and pop in the same cycle with count=2 -> count stays 2; data order is preserved.
REQ-040 Scenario: reset_n asserted during ACK -> next edge ack=0 and FIFO empty; req still high -> new capture after synchronizer delay.
REQ-041 Scenario: irq_en=1 with the FIFO empty -> irq=0; one push -> irq=1; pop -> irq=0; write 0x2 to address 3 with count=3 -> empty=1.
